cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 block at the M stage: the consuming end of the exception information carried down the pipeline (exception code, branch-delay flag, PC). It samples hardware interrupt lines, arbitrates them against synchronous exceptions, and asserts `int_req`, which flushes the pipeline registers and redirects fetch to 0x0000_4180. It also holds SR, Cause, EPC and PRId, serves `mtc0`/`mfc0`, and clears exception level on `eret`.

## Interface
- `PRID`, default 32'h0000_2023: constant value returned for PRId (reg 15).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `we`  in  1  `mtc0` write enable (M stage).
- `cp0_addr`  in  5  CP0 register number for read and write.
- `cp0_wdata`  in  32  `mtc0` write data.
- `cp0_rdata`  out  32  `mfc0` read data (combinational).
- `M_pc`  in  32  PC of the instruction in M.
- `M_isBD`  in  1  M instruction sits in a branch delay slot.
- `M_exCode`  in  5  exception code of the M instruction; 0 = none.
- `M_eret`  in  1  `eret` in M.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `int_req`  out  1  take exception/interrupt this cycle (combinational).
- `epc_out`  out  32  current EPC, feeds the `eret` redirect.

## Operation
- SR (12): IM[15:10], EXL[1], IE[0]. Other bits are hard 0 and read as 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0. Software cannot write this register.
- EPC (14): 32 bits, writable by `mtc0`.
- PRId (15): reads `PRID`; writes are ignored.
- Any other address reads 0; writes to it are ignored.
- Interrupt pending: `irq = IE & |(hw_int & IM)`.
- Request logic: `int_req = ~EXL & (irq | (M_exCode != 0))`.
- Cause.IP is loaded from `hw_int` on every non-reset edge, including while EXL = 1.
- On an edge where `int_req` = 1:
  - EXL is set to 1.
  - BD is loaded from `M_isBD`.
  - ExcCode is set to 0 if `irq` = 1 (interrupt beats exception). Otherwise it is set to `M_exCode`.
  - EPC is set to `M_isBD ? M_pc - 4 : M_pc` (32-bit wrap, no masking).
- On an edge where `M_eret` = 1 and `int_req` = 0: EXL is cleared to 0. No other field changes.
- On an edge where `we` = 1, `int_req` = 0 and `M_eret` = 0:
  - Addr 12 writes IM, EXL and IE from the matching `cp0_wdata` bits.
  - Addr 14 writes EPC.
- Precedence per edge: reset, then `int_req`, then `M_eret`, then `we`. A suppressed `mtc0` is lost; the pipeline replays it after the handler.
- Reads are combinational from the current register state. There is no write-to-read bypass: an `mfc0` in the same cycle as an `mtc0` returns the old value.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0. Hence `int_req` = 0 and `epc_out` = 0 after the reset edge.
- `int_req` is valid in the same cycle as its inputs. State updates at the following rising edge. EXL = 1 from then on masks further requests, so one exception produces exactly one `int_req` cycle.
- `hw_int` is not latched for arbitration. A line dropped before a cycle with IE = 1 and EXL = 0 produces no request. Cause.IP shows its value one edge later.
- `mtc0` SR enabling IE/IM takes effect on the next cycle's `int_req`. The same applies to `mtc0` setting EXL = 1, which blocks requests from the next cycle.
- `eret` clears EXL at the edge. A pending `irq` then raises `int_req` in the next cycle.
- If reset is asserted mid-handler (EXL = 1), all registers return to 0 at that edge.

## Test plan
- Reset, then IM = 6'b000001, IE = 1, EXL = 0; `hw_int` = 1, `M_pc` = 0x3008, `M_isBD` = 0 -> `int_req` = 1 that cycle; next cycle EPC = 0x3008, ExcCode = 0, EXL = 1, `int_req` = 0.
- IE = 0; `M_exCode` = 5'd10, `M_pc` = 0x3010, `M_isBD` = 1 -> `int_req` = 1; then EPC = 0x300C, BD = 1, ExcCode = 10.
- Simultaneous enabled `hw_int` and `M_exCode` = 4 -> ExcCode = 0. Same cycle with `we` = 1, addr 14, data 0x1234 -> EPC not 0x1234.
- EXL = 1, `M_eret` = 1 with `hw_int` still enabled -> EXL = 0 after the edge; `int_req` = 1 in the following cycle.
- `mtc0` addr 12 with data 0xFFFF_FFFF -> `mfc0` 12 returns 0x0000_FC03. `mtc0` to addr 13 or 15 -> no change; addr 15 reads `PRID`; addr 7 reads 0.
- Reset asserted while EXL = 1 and EPC = 0x4000 -> next cycle all of SR, Cause, EPC read 0 and `int_req` = 0.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration, and the single-cycle int_req that flushes and redirects fetch.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_2023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] M_pc,
  input  logic        M_isBD,
  input  logic [4:0]  M_exCode,
  input  logic        M_eret,
  input  logic [5:0]  hw_int,
  output logic        int_req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        irq;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // hw_int is arbitrated live, not from Cause.IP, so a dropped line never fires.
  assign irq     = ie_q & (|(hw_int & im_q));
  assign int_req = ~exl_q & (irq | (M_exCode != 5'd0));
  assign epc_out = epc_q;

  assign sr_word    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_word = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};

  // Per-edge precedence: int_req over eret over mtc0; a suppressed mtc0 is dropped.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (int_req) begin
      exl_d      = 1'b1;
      bd_d       = M_isBD;
      exc_code_d = irq ? 5'd0 : M_exCode;
      epc_d      = M_isBD ? (M_pc - 32'd4) : M_pc;
    end else if (M_eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (cp0_addr)
        ADDR_SR: begin
          im_d  = cp0_wdata[15:10];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        ADDR_EPC: epc_d = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // No write-to-read bypass: mfc0 sees the registered state only.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_word;
      ADDR_CAUSE: cp0_rdata = cause_word;
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: inputs change on the falling edge, outputs are
// checked just after it, state advances on the rising edge.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] M_pc;
  logic        M_isBD;
  logic [4:0]  M_exCode;
  logic        M_eret;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [31:0] epc_out;

  int n_checks;
  int n_fail;

  cp0_unit #(.PRID(32'h0000_2023)) dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .M_pc(M_pc),
    .M_isBD(M_isBD), .M_exCode(M_exCode), .M_eret(M_eret),
    .hw_int(hw_int), .int_req(int_req), .epc_out(epc_out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    we        = 1'b1;
    cp0_addr  = addr;
    cp0_wdata = data;
    tick();
    we        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
    n_checks++;
    if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc_out: got %h expected 00000000", epc_out); end
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_sr: got %h expected 00000000", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h expected 00000000", cp0_rdata); end
  endtask

  task automatic test_irq();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    M_pc   = 32'h0000_3008;
    M_isBD = 1'b0;
    #1;
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL irq_req: got %b expected 1", int_req); end
    tick();
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL irq_single_cycle: got %b expected 0", int_req); end
    n_checks++;
    if (epc_out !== 32'h0000_3008) begin n_fail++; $display("FAIL irq_epc: got %h expected 00003008", epc_out); end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL irq_cause: got %h expected 00000400", cp0_rdata); end
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_0403) begin n_fail++; $display("FAIL irq_sr_exl: got %h expected 00000403", cp0_rdata); end
    hw_int = 6'b000000;
    M_eret = 1'b1;
    tick();
    M_eret = 1'b0;
  endtask

  task automatic test_exception();
    mtc0(5'd12, 32'h0000_0400);
    M_exCode = 5'd10;
    M_pc     = 32'h0000_3010;
    M_isBD   = 1'b1;
    #1;
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL exc_req: got %b expected 1", int_req); end
    tick();
    #1;
    // exCode still held: EXL must mask it so only one request cycle occurs
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL exc_back_to_back: got %b expected 0", int_req); end
    M_exCode = 5'd0;
    M_isBD   = 1'b0;
    n_checks++;
    if (epc_out !== 32'h0000_300C) begin n_fail++; $display("FAIL exc_epc_bd: got %h expected 0000300c", epc_out); end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h8000_0028) begin n_fail++; $display("FAIL exc_cause: got %h expected 80000028", cp0_rdata); end
    M_eret = 1'b1;
    tick();
    M_eret = 1'b0;
  endtask

  task automatic test_priority();
    mtc0(5'd12, 32'h0000_0401);
    hw_int    = 6'b000001;
    M_exCode  = 5'd4;
    M_pc      = 32'h0000_3020;
    M_isBD    = 1'b0;
    we        = 1'b1;
    cp0_addr  = 5'd14;
    cp0_wdata = 32'h0000_1234;
    #1;
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b expected 1", int_req); end
    tick();
    we       = 1'b0;
    M_exCode = 5'd0;
    #1;
    n_checks++;
    if (epc_out !== 32'h0000_3020) begin n_fail++; $display("FAIL prio_mtc0_suppressed: got %h expected 00003020", epc_out); end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL prio_exccode_irq: got %h expected 00000400", cp0_rdata); end
  endtask

  task automatic test_eret();
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL eret_masked_before: got %b expected 0", int_req); end
    M_eret = 1'b1;
    tick();
    M_eret = 1'b0;
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_0401) begin n_fail++; $display("FAIL eret_sr: got %h expected 00000401", cp0_rdata); end
    n_checks++;
    if (int_req !== 1'b1) begin n_fail++; $display("FAIL eret_pending_irq: got %b expected 1", int_req); end
    n_checks++;
    if (epc_out !== 32'h0000_3020) begin n_fail++; $display("FAIL eret_epc_kept: got %h expected 00003020", epc_out); end
    hw_int = 6'b000000;
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL eret_line_dropped: got %b expected 0", int_req); end
  endtask

  task automatic test_sr_mask();
    mtc0(5'd12, 32'hFFFF_FFFF);
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_FC03) begin n_fail++; $display("FAIL sr_mask: got %h expected 0000fc03", cp0_rdata); end
    hw_int = 6'b100000;
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL mtc0_exl_masks: got %b expected 0", int_req); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_8000) begin n_fail++; $display("FAIL cause_readonly: got %h expected 00008000", cp0_rdata); end
    mtc0(5'd15, 32'h0000_0000);
    cp0_addr = 5'd15; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_2023) begin n_fail++; $display("FAIL prid: got %h expected 00002023", cp0_rdata); end
    mtc0(5'd7, 32'hFFFF_FFFF);
    cp0_addr = 5'd7; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL addr7_zero: got %h expected 00000000", cp0_rdata); end
    n_checks++;
    if (epc_out !== 32'h0000_3020) begin n_fail++; $display("FAIL addr7_no_side_effect: got %h expected 00003020", epc_out); end
    we        = 1'b1;
    cp0_addr  = 5'd14;
    cp0_wdata = 32'h0000_4000;
    #1;
    n_checks++;
    if (cp0_rdata !== 32'h0000_3020) begin n_fail++; $display("FAIL no_bypass: got %h expected 00003020", cp0_rdata); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (epc_out !== 32'h0000_4000) begin n_fail++; $display("FAIL epc_write: got %h expected 00004000", epc_out); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL midreset_int_req: got %b expected 0", int_req); end
    n_checks++;
    if (epc_out !== 32'h0) begin n_fail++; $display("FAIL midreset_epc: got %h expected 00000000", epc_out); end
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_sr: got %h expected 00000000", cp0_rdata); end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_cause: got %h expected 00000000", cp0_rdata); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    we        = 1'b0;
    cp0_addr  = 5'd0;
    cp0_wdata = 32'h0;
    M_pc      = 32'h0;
    M_isBD    = 1'b0;
    M_exCode  = 5'd0;
    M_eret    = 1'b0;
    hw_int    = 6'd0;
    @(negedge clk);
    test_reset();
    test_irq();
    test_exception();
    test_priority();
    test_eret();
    test_sr_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
